// File: rtl/mul_issue_ctrl_pkg.sv
// mul_issue_ctrl_pkg: shared definitions for the multiplier issue controller.
//   DataWidth    - architectural operand width
//   mul_op_e     - multiply op encodings (MulOp input)
//   hold_flag_e  - hold flag encodings driven to the final adder stage
//   state_e      - issue FSM state encoding
package mul_issue_ctrl_pkg;

  localparam int unsigned DataWidth = 64;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE_F  = 2'b00,
    BUSY_F  = 2'b01,
    ABORT_F = 2'b10
  } hold_flag_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    ABORT = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/mul_operand_ext.sv
// mul_operand_ext: sign/zero extension of both multiplier operands by op.
//   op_i   - multiply op (MUL/MULH/MULHSU/MULHU)
//   rs1_i  - first source operand
//   rs2_i  - second source operand
//   opa_o  - rs1 extended to DataWidth+1 (signed unless MULHU)
//   opb_o  - rs2 extended to DataWidth+1 (signed for MUL/MULH only)
module mul_operand_ext
  import mul_issue_ctrl_pkg::*;
(
  input  mul_op_e              op_i,
  input  logic [DataWidth-1:0] rs1_i,
  input  logic [DataWidth-1:0] rs2_i,
  output logic [DataWidth:0]   opa_o,
  output logic [DataWidth:0]   opb_o
);

  logic sign_a;
  logic sign_b;

  assign sign_a = (op_i != OP_MULHU);
  assign sign_b = (op_i == OP_MUL) || (op_i == OP_MULH);

  assign opa_o = {sign_a & rs1_i[DataWidth-1], rs1_i};
  assign opb_o = {sign_b & rs2_i[DataWidth-1], rs2_i};

endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: EX-stage initiator for the multi-cycle multiplier hold
// handshake. Latches extended operands, raises the hold flag, stalls EX until
// the final adder stage returns its end pulse, then selects the product half.
//   Clk, Rst             - clock, synchronous active-high reset
//   MulReq, MulOp        - multiply request and op from EX
//   Rs1Data, Rs2Data     - source operands
//   FlushFromCtrl        - kills any in-flight multiply
//   MulHoldEndFromMul    - end pulse from the final adder stage
//   MulSumFromMul        - 2*DataWidth product, valid with the end pulse
//   MulOpA, MulOpB       - registered extended operands
//   MulHoldFlagToMul     - hold flag: 00 idle, 01 busy, 10 abort
//   MulStallReq          - combinational stall request to pipeline control
//   MulResult            - selected result, held until next capture
//   MulResultValid       - one-cycle result strobe
// Build option: MUL_ZERO_BYPASS_EN - zero operand requests skip the multiplier.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
(
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     MulReq,
  input  logic [1:0]               MulOp,
  input  logic [DataWidth-1:0]     Rs1Data,
  input  logic [DataWidth-1:0]     Rs2Data,
  input  logic                     FlushFromCtrl,
  input  logic                     MulHoldEndFromMul,
  input  logic [2*DataWidth-1:0]   MulSumFromMul,
  output logic [DataWidth:0]       MulOpA,
  output logic [DataWidth:0]       MulOpB,
  output logic [1:0]               MulHoldFlagToMul,
  output logic                     MulStallReq,
  output logic [DataWidth-1:0]     MulResult,
  output logic                     MulResultValid
);

  state_e               state_q, state_d;
  hold_flag_e           flag_q, flag_d;
  mul_op_e              op_q, op_d;
  logic [DataWidth:0]   opa_q, opa_d;
  logic [DataWidth:0]   opb_q, opb_d;
  logic [DataWidth-1:0] result_q, result_d;
  logic [DataWidth:0]   ext_a, ext_b;
  logic                 accept;
  logic                 bypass;

  mul_operand_ext u_ext (
    .op_i  (mul_op_e'(MulOp)),
    .rs1_i (Rs1Data),
    .rs2_i (Rs2Data),
    .opa_o (ext_a),
    .opb_o (ext_b)
  );

  assign accept = (state_q == IDLE) && MulReq && !FlushFromCtrl;

`ifdef MUL_ZERO_BYPASS_EN
  assign bypass = accept && ((Rs1Data == '0) || (Rs2Data == '0));
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    flag_d   = flag_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = mul_op_e'(MulOp);
          if (bypass) begin
            result_d = '0;
            state_d  = DONE;
          end else begin
            opa_d   = ext_a;
            opb_d   = ext_b;
            flag_d  = BUSY_F;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Flush wins over an end pulse arriving in the same cycle.
        if (FlushFromCtrl) begin
          flag_d  = ABORT_F;
          state_d = ABORT;
        end else if (MulHoldEndFromMul) begin
          result_d = (op_q == OP_MUL) ? MulSumFromMul[DataWidth-1:0]
                                      : MulSumFromMul[2*DataWidth-1:DataWidth];
          flag_d   = IDLE_F;
          state_d  = DONE;
        end
      end
      ABORT: begin
        flag_d  = IDLE_F;
        state_d = IDLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        flag_d  = IDLE_F;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      flag_q   <= IDLE_F;
      op_q     <= OP_MUL;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      flag_q   <= flag_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign MulOpA           = opa_q;
  assign MulOpB           = opb_q;
  assign MulHoldFlagToMul = flag_q;
  assign MulResult        = result_q;
  assign MulResultValid   = (state_q == DONE) && !FlushFromCtrl;
  assign MulStallReq      = accept || (state_q == WAIT) || (state_q == ABORT);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed self-checking bench for mul_issue_ctrl.
// Expected results are queued when a request is driven and popped on the
// result strobe. Honours MUL_ZERO_BYPASS_EN for the zero-operand case.
module tb_mul_issue_ctrl;

  localparam int unsigned W = 64;

  logic           Clk = 1'b0;
  logic           Rst;
  logic           MulReq;
  logic [1:0]     MulOp;
  logic [W-1:0]   Rs1Data, Rs2Data;
  logic           FlushFromCtrl;
  logic           MulHoldEndFromMul;
  logic [2*W-1:0] MulSumFromMul;
  logic [W:0]     MulOpA, MulOpB;
  logic [1:0]     MulHoldFlagToMul;
  logic           MulStallReq;
  logic [W-1:0]   MulResult;
  logic           MulResultValid;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];

  always #5 Clk = ~Clk;

  mul_issue_ctrl dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .MulReq            (MulReq),
    .MulOp             (MulOp),
    .Rs1Data           (Rs1Data),
    .Rs2Data           (Rs2Data),
    .FlushFromCtrl     (FlushFromCtrl),
    .MulHoldEndFromMul (MulHoldEndFromMul),
    .MulSumFromMul     (MulSumFromMul),
    .MulOpA            (MulOpA),
    .MulOpB            (MulOpB),
    .MulHoldFlagToMul  (MulHoldFlagToMul),
    .MulStallReq       (MulStallReq),
    .MulResult         (MulResult),
    .MulResultValid    (MulResultValid)
  );

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Called in the cycle the strobe is expected: strobe high, result matches queue head.
  task automatic check_done(input string tag);
    logic [W-1:0] exp;
    chk({tag, "_valid"}, MulResultValid, 1'b1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=result expected=queued_entry", tag);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_result"}, MulResult, exp);
    end
  endtask

  initial begin
    Rst = 1'b1; MulReq = 1'b0; MulOp = 2'b00; Rs1Data = '0; Rs2Data = '0;
    FlushFromCtrl = 1'b0; MulHoldEndFromMul = 1'b0; MulSumFromMul = '0;
    tick(); tick();
    Rst = 1'b0;
    settle();
    chk("rst_flag",   MulHoldFlagToMul, 2'b00);
    chk("rst_stall",  MulStallReq, 1'b0);
    chk("rst_valid",  MulResultValid, 1'b0);
    chk("rst_result", MulResult, '0);
    chk("rst_opa",    MulOpA, '0);
    chk("rst_opb",    MulOpB, '0);

    // MUL 3 * -5, end pulse three cycles after the flag goes busy.
    MulReq = 1'b1; MulOp = 2'b00; Rs1Data = 64'd3; Rs2Data = 64'hFFFF_FFFF_FFFF_FFFB;
    settle();
    chk("mul_req_stall", MulStallReq, 1'b1);
    chk("mul_req_flag",  MulHoldFlagToMul, 2'b00);
    sb.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    tick();
    chk("mul_flag_busy", MulHoldFlagToMul, 2'b01);
    chk("mul_opa", MulOpA, 65'h0_0000_0000_0000_0003);
    chk("mul_opb", MulOpB, 65'h1_FFFF_FFFF_FFFF_FFFB);
    chk("mul_wait_stall1", MulStallReq, 1'b1);
    tick();
    chk("mul_wait_stall2", MulStallReq, 1'b1);
    tick();
    chk("mul_wait_stall3", MulStallReq, 1'b1);
    chk("mul_wait_novalid", MulResultValid, 1'b0);
    tick();
    MulHoldEndFromMul = 1'b1;
    MulSumFromMul = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1};
    settle();
    chk("mul_end_stall", MulStallReq, 1'b1);
    tick();
    MulHoldEndFromMul = 1'b0; MulSumFromMul = '0; MulReq = 1'b0;
    settle();
    check_done("mul");
    chk("mul_done_stall", MulStallReq, 1'b0);
    chk("mul_done_flag",  MulHoldFlagToMul, 2'b00);
    tick();
    chk("mul_valid_once", MulResultValid, 1'b0);
    chk("mul_result_hold", MulResult, 64'hFFFF_FFFF_FFFF_FFF1);

    // MULHU all-ones.
    MulReq = 1'b1; MulOp = 2'b11; Rs1Data = '1; Rs2Data = '1;
    settle();
    sb.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    chk("mulhu_opa", MulOpA, 65'h0_FFFF_FFFF_FFFF_FFFF);
    chk("mulhu_opb", MulOpB, 65'h0_FFFF_FFFF_FFFF_FFFF);
    tick();
    MulHoldEndFromMul = 1'b1;
    MulSumFromMul = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    tick();
    MulHoldEndFromMul = 1'b0; MulSumFromMul = '0; MulReq = 1'b0;
    settle();
    check_done("mulhu");
    tick();

    // MULHSU -1 * 2: upper half selected.
    MulReq = 1'b1; MulOp = 2'b10; Rs1Data = '1; Rs2Data = 64'd2;
    settle();
    sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("mulhsu_opa", MulOpA, 65'h1_FFFF_FFFF_FFFF_FFFF);
    chk("mulhsu_opb", MulOpB, 65'h0_0000_0000_0000_0002);
    tick();
    MulHoldEndFromMul = 1'b1;
    MulSumFromMul = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
    tick();
    MulHoldEndFromMul = 1'b0; MulSumFromMul = '0; MulReq = 1'b0;
    settle();
    check_done("mulhsu");
    tick();

    // Flush in IDLE alongside a request: not accepted.
    MulReq = 1'b1; MulOp = 2'b00; Rs1Data = 64'd7; Rs2Data = 64'd9; FlushFromCtrl = 1'b1;
    settle();
    chk("idleflush_stall", MulStallReq, 1'b0);
    tick();
    FlushFromCtrl = 1'b0;
    settle();
    chk("idleflush_flag", MulHoldFlagToMul, 2'b00);

    // Request now accepted; flush and end pulse collide in WAIT.
    tick();
    chk("flush_busy", MulHoldFlagToMul, 2'b01);
    tick();
    FlushFromCtrl = 1'b1; MulHoldEndFromMul = 1'b1; MulSumFromMul = 128'h123;
    settle();
    chk("flush_stall_wait", MulStallReq, 1'b1);
    tick();
    FlushFromCtrl = 1'b0; MulHoldEndFromMul = 1'b0; MulSumFromMul = '0; MulReq = 1'b0;
    settle();
    chk("flush_abort_flag",  MulHoldFlagToMul, 2'b10);
    chk("flush_abort_stall", MulStallReq, 1'b1);
    chk("flush_abort_valid", MulResultValid, 1'b0);
    tick();
    chk("flush_idle_flag",  MulHoldFlagToMul, 2'b00);
    chk("flush_idle_stall", MulStallReq, 1'b0);
    chk("flush_idle_valid", MulResultValid, 1'b0);
    chk("flush_result_kept", MulResult, 64'hFFFF_FFFF_FFFF_FFFF);

    // Zero operand MUL.
    MulReq = 1'b1; MulOp = 2'b00; Rs1Data = '0; Rs2Data = 64'd5;
    settle();
    chk("zero_req_stall", MulStallReq, 1'b1);
    sb.push_back('0);
`ifdef MUL_ZERO_BYPASS_EN
    tick();
    MulReq = 1'b0;
    settle();
    chk("zero_byp_flag",  MulHoldFlagToMul, 2'b00);
    chk("zero_byp_stall", MulStallReq, 1'b0);
    check_done("zero_byp");
`else
    tick();
    chk("zero_wait_flag", MulHoldFlagToMul, 2'b01);
    chk("zero_wait_stall", MulStallReq, 1'b1);
    tick();
    MulHoldEndFromMul = 1'b1; MulSumFromMul = '0;
    tick();
    MulHoldEndFromMul = 1'b0; MulReq = 1'b0;
    settle();
    check_done("zero_wait");
`endif
    tick();

    // Reset asserted mid-WAIT, then a stray end pulse.
    MulReq = 1'b1; MulOp = 2'b11; Rs1Data = 64'd5; Rs2Data = 64'd6;
    tick();
    chk("rstw_busy", MulHoldFlagToMul, 2'b01);
    Rst = 1'b1; MulReq = 1'b0;
    tick();
    Rst = 1'b0;
    settle();
    chk("rstw_flag",   MulHoldFlagToMul, 2'b00);
    chk("rstw_opa",    MulOpA, '0);
    chk("rstw_opb",    MulOpB, '0);
    chk("rstw_result", MulResult, '0);
    chk("rstw_stall",  MulStallReq, 1'b0);
    chk("rstw_valid",  MulResultValid, 1'b0);
    MulHoldEndFromMul = 1'b1; MulSumFromMul = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    tick();
    MulHoldEndFromMul = 1'b0;
    settle();
    chk("stray_valid",  MulResultValid, 1'b0);
    chk("stray_result", MulResult, '0);
    chk("stray_flag",   MulHoldFlagToMul, 2'b00);
    chk("sb_drained",   sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

EX-stage initiator for the multi-cycle multiplier hold handshake. Accepts a multiply request from the EX stage and latches sign-adjusted operands for the partial-product/CLA datapath. Drives the hold flag into the final adder stage and stalls the pipeline until that stage returns its end pulse. Selects the low or high half of the 2×DataWidth product as the EX result.

## Interface
- `DataWidth`, from shared defines (64): architectural operand width.
- `Clk` in 1: single clock.
- `Rst` in 1: synchronous, active-high reset.
- `MulReq` in 1: EX presents a multiply; held stable while `MulStallReq`=1.
- `MulOp` in 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `Rs1Data`, `Rs2Data` in DataWidth: source operands.
- `FlushFromCtrl` in 1: kill any in-flight multiply.
- `MulHoldEndFromMul` in 1: end pulse from the final adder stage.
- `MulSumFromMul` in 2×DataWidth: product from the final adder stage; valid when the end pulse is high.
- `MulOpA`, `MulOpB` out DataWidth+1: registered operands, sign- or zero-extended.
- `MulHoldFlagToMul` out 2: 00 idle, 01 busy, 10 abort, 11 reserved (never driven).
- `MulStallReq` out 1: stall request to pipeline control.
- `MulResult` out DataWidth: selected result.
- `MulResultValid` out 1: one-cycle result strobe.

## Operation
- FSM states: IDLE, WAIT, ABORT, DONE. Reset state is IDLE.
- Reset values of all outputs are 0, which makes the hold flag 00.
- IDLE with `MulReq`=1 and no flush:
  - Register the operands and the op.
  - `MulOpA` is `Rs1Data` sign-extended for MUL, MULH and MULHSU, and zero-extended for MULHU.
  - `MulOpB` is `Rs2Data` sign-extended for MUL and MULH, and zero-extended for MULHSU and MULHU.
  - Set flag to 01 and go to WAIT.
- WAIT: hold flag 01 and all operands.
  - On `MulHoldEndFromMul`=1, capture the result into `MulResult`, set flag to 00 and go to DONE.
  - For MUL the result is `MulSumFromMul[DataWidth-1:0]`. For all other ops it is `MulSumFromMul[2×DataWidth-1:DataWidth]`.
- DONE: `MulResultValid`=1 for exactly this cycle, then go to IDLE. `MulResult` holds its value until the next capture.
- Flush in WAIT: set flag to 10 and go to ABORT. Flush has priority over an end pulse in the same cycle.
- ABORT: lasts one cycle. Any end pulse is ignored, no result is captured, flag returns to 00 and the FSM goes to IDLE.
- Flush in IDLE or DONE: no request is accepted; the FSM goes to or stays in IDLE. `MulResultValid` in DONE is suppressed.
- An end pulse seen in IDLE, ABORT or DONE is ignored.
- `MulStallReq` (combinational) is 1 when `MulReq`=1 in IDLE with no flush, and whenever the FSM is in WAIT or ABORT. Otherwise it is 0.
- `MulStallReq`=0 in DONE, so EX retires the instruction that cycle. A `MulReq` seen in DONE is not accepted; the next request is taken in IDLE.

## Timing
- Request at cycle N: flag is 01 from N+1.
- End pulse at cycle M ≥ N+2: result and `MulResultValid` at M+1, stall released at M+1.
- Minimum request-to-valid latency is 3 cycles. Back-to-back requests are spaced by at least one IDLE cycle.
- Flag is registered and never changes combinationally from inputs.

## Configuration
- `MUL_ZERO_BYPASS_EN` defined:
  - A request in IDLE with `Rs1Data`=0 or `Rs2Data`=0 does not touch the multiplier; the flag stays 00.
  - `MulResult`<=0 and the FSM goes directly to DONE.
  - `MulStallReq` is 1 for the request cycle only.
  - Flush in that cycle cancels the bypass.
- `MUL_ZERO_BYPASS_EN` undefined: zero operands take the normal WAIT path.

## Structure
- Shared defines/package holds:
  - `DataWidth`.
  - Mul op encodings: MUL, MULH, MULHSU, MULHU.
  - Hold flag encodings: IDLE_F=2'b00, BUSY_F=2'b01, ABORT_F=2'b10.
  - FSM state encoding.
- One natural sub-module: `mul_operand_ext`, the combinational sign/zero extension of both operands from `MulOp`. The FSM, result selection and stall logic stay in the top module.

## Test plan
- MUL, Rs1=3, Rs2=−5; end pulse 3 cycles after the flag goes to 01, with Sum=128'hFFFF…FFF1 → `MulResult`=64'hFFFF_FFFF_FFFF_FFF1, one-cycle `MulResultValid`, stall high from the request through the end cycle.
- MULHU, Rs1=Rs2=64'hFFFF_FFFF_FFFF_FFFF → `MulOpA`=`MulOpB`=65'h0_FFFF_FFFF_FFFF_FFFF; with Sum=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 → `MulResult`=64'hFFFF_FFFF_FFFF_FFFE.
- MULHSU, Rs1=−1, Rs2=2 → `MulOpA`=65'h1_FFFF_FFFF_FFFF_FFFF, `MulOpB`=65'h0_0000_0000_0000_0002; upper half of Sum is selected.
- Flush in the same cycle as the end pulse in WAIT → flag 10 for one cycle then 00, no `MulResultValid`, stall drops after ABORT, `MulResult` unchanged.
- `Rst` asserted mid-WAIT → next cycle state IDLE, flag 00, all outputs 0; a later end pulse is ignored.
- With `MUL_ZERO_BYPASS_EN` defined, MUL with Rs1=0 → flag stays 00, `MulResultValid` the next cycle with `MulResult`=0. With the macro undefined, the same stimulus takes the WAIT path.
